seq_multiply: RTL and testbench

Parametrised sequential multiplier. It is the successor to the combinational 5x5 unsigned multiply test design. Operands are accepted over a valid/ready handshake and multiplied by an iterative radix-2 shift-add engine, one multiplier bit per cycle. A per-transaction is_signed flag selects unsigned or two's-complement operation. The result is held under an output valid/ready handshake. The block is mapped onto the fabric and driven from the pad I/O in the random formal benches.

---
 rtl/seq_multiply.sv | 131 +++++++++++++
 tb/tb_seq_multiply.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiply.sv
// seq_multiply: iterative radix-2 shift-add multiplier with valid/ready
// handshakes on the operand and product sides. Signed operation is done on
// magnitudes, and the stored result sign is applied when the product is loaded.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands; in_ready=1
// RUN   | one multiplier bit per cycle for B_WIDTH cycles; busy=1
// DONE  | product held on dataout with out_valid=1 until out_ready
module seq_multiply #(
    parameter int A_WIDTH = 5,
    parameter int B_WIDTH = 5,
    parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic               clock0,
    input  logic               global_resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_signed,
    input  logic [A_WIDTH-1:0] dataa,
    input  logic [B_WIDTH-1:0] datab,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] dataout,
    output logic               busy
);

    localparam int CNT_W = $clog2(B_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [P_WIDTH:0]   r_mcand;
    logic [B_WIDTH-1:0] r_mplier;
    logic [P_WIDTH:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign;
    logic [P_WIDTH-1:0] r_dataout;
    logic               r_out_valid;
    logic               r_in_ready;
    logic               r_busy;

    // The multiplicand magnitude carries one extra bit so -2^(A-1) keeps its
    // magnitude. The multiplier magnitude 2^(B-1) still fits in B bits unsigned.
    logic [A_WIDTH:0]   w_a_ext;
    logic [A_WIDTH:0]   w_a_mag;
    logic [B_WIDTH-1:0] w_b_mag;
    logic               w_sign;
    logic [P_WIDTH:0]   w_addend;
    logic [P_WIDTH:0]   w_acc_next;
    logic [P_WIDTH-1:0] w_prod_lo;
    logic [P_WIDTH-1:0] w_result;

    // Operand magnitude/sign conditioning and the shift-add datapath
    always_comb begin
        w_a_ext    = {dataa[A_WIDTH-1], dataa};
        w_a_mag    = (is_signed && dataa[A_WIDTH-1]) ? -w_a_ext : {1'b0, dataa};
        w_b_mag    = (is_signed && datab[B_WIDTH-1]) ? -datab : datab;
        w_sign     = is_signed & (dataa[A_WIDTH-1] ^ datab[B_WIDTH-1]);
        w_addend   = r_mplier[0] ? r_mcand : '0;
        w_acc_next = r_acc + w_addend;
        w_prod_lo  = w_acc_next[P_WIDTH-1:0];
        w_result   = r_sign ? -w_prod_lo : w_prod_lo;
    end

    // Control FSM with registered handshake outputs and the datapath registers
    always_ff @(posedge clock0 or negedge global_resetn) begin
        if (!global_resetn) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_dataout   <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand    <= {{B_WIDTH{1'b0}}, w_a_mag};
                        r_mplier   <= w_b_mag;
                        r_sign     <= w_sign;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(B_WIDTH - 1)) begin
                        r_dataout   <= w_result;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign dataout   = r_dataout;
    assign busy      = r_busy;

endmodule

// File: tb/tb_seq_multiply.sv
// Bench for seq_multiply: directed vector table, hand-written handshake,
// backpressure and reset sequences, then random regressions on a 5x5 and an
// 8x6 instance against an arithmetic reference.
module tb_seq_multiply;

    logic        clock0 = 1'b0;
    logic        global_resetn;

    logic        in_valid, is_signed, out_ready;
    logic [4:0]  dataa, datab;
    logic        in_ready, out_valid, busy;
    logic [9:0]  dataout;

    logic        in_valid2, is_signed2, out_ready2;
    logic [7:0]  dataa2;
    logic [5:0]  datab2;
    logic        in_ready2, out_valid2, busy2;
    logic [13:0] dataout2;

    int checks = 0;
    int errors = 0;

    always #5 clock0 = ~clock0;

    seq_multiply dut (
        .clock0(clock0), .global_resetn(global_resetn),
        .in_valid(in_valid), .in_ready(in_ready), .is_signed(is_signed),
        .dataa(dataa), .datab(datab),
        .out_valid(out_valid), .out_ready(out_ready),
        .dataout(dataout), .busy(busy)
    );

    seq_multiply #(.A_WIDTH(8), .B_WIDTH(6)) dut2 (
        .clock0(clock0), .global_resetn(global_resetn),
        .in_valid(in_valid2), .in_ready(in_ready2), .is_signed(is_signed2),
        .dataa(dataa2), .datab(datab2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .dataout(dataout2), .busy(busy2)
    );

    typedef struct {
        logic       s;
        logic [4:0] a;
        logic [4:0] b;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic longint model(input logic s, input longint a_in, input longint b_in,
                                     input int aw, input int bw, input int pw);
        longint a, b;
        a = a_in;
        b = b_in;
        if (s && a[aw-1]) a = a - (longint'(1) << aw);
        if (s && b[bw-1]) b = b - (longint'(1) << bw);
        return (a * b) & ((longint'(1) << pw) - 1);
    endfunction

    // One transaction on the 5x5 instance; called and returning at a negedge.
    task automatic run1(input logic s, input logic [4:0] a, input logic [4:0] b,
                        input int stall, output int lat, output int busy_cnt,
                        output logic [9:0] res, output logic ready_after);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clock0);
            guard++;
        end
        is_signed = s;
        dataa     = a;
        datab     = b;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(negedge clock0);
        in_valid  = 1'b0;
        dataa     = 5'($urandom_range(0, 31));
        datab     = 5'($urandom_range(0, 31));
        is_signed = 1'($urandom_range(0, 1));
        lat = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 50) begin
            busy_cnt += int'(busy);
            @(negedge clock0);
            lat++;
        end
        for (int i = 0; i < stall; i++) @(negedge clock0);
        res = dataout;
        out_ready = 1'b1;
        @(negedge clock0);
        ready_after = in_ready && !out_valid;
    endtask

    // One transaction on the 8x6 instance.
    task automatic run2(input logic s, input logic [7:0] a, input logic [5:0] b,
                        input int stall, output int lat, output logic [13:0] res);
        int guard;
        guard = 0;
        while (!in_ready2 && guard < 50) begin
            @(negedge clock0);
            guard++;
        end
        is_signed2 = s;
        dataa2     = a;
        datab2     = b;
        in_valid2  = 1'b1;
        out_ready2 = (stall == 0);
        @(negedge clock0);
        in_valid2  = 1'b0;
        dataa2     = 8'($urandom_range(0, 255));
        datab2     = 6'($urandom_range(0, 63));
        lat = 0;
        while (!out_valid2 && lat < 50) begin
            @(negedge clock0);
            lat++;
        end
        for (int i = 0; i < stall; i++) @(negedge clock0);
        res = dataout2;
        out_ready2 = 1'b1;
        @(negedge clock0);
    endtask

    initial begin
        int         lat, bcnt, bad, guard;
        logic [9:0] res;
        logic [13:0] res2;
        logic       rdy;
        logic       s;
        logic [4:0] a, b;
        logic [7:0] a2;
        logic [5:0] b2;

        vecs[0] = '{1'b0, 5'd31,  5'd31,  10'h3C1};
        vecs[1] = '{1'b1, 5'h10,  5'h10,  10'h100};
        vecs[2] = '{1'b1, 5'h1F,  5'h03,  10'h3FD};
        vecs[3] = '{1'b1, 5'h00,  5'h10,  10'h000};
        vecs[4] = '{1'b0, 5'd7,   5'd9,   10'd63};
        vecs[5] = '{1'b1, 5'h0F,  5'h10,  10'h310};
        vecs[6] = '{1'b1, 5'h1F,  5'h1F,  10'h001};
        vecs[7] = '{1'b0, 5'h1F,  5'h03,  10'h05D};
        vecs[8] = '{1'b0, 5'h10,  5'h10,  10'h100};
        vecs[9] = '{1'b0, 5'd0,   5'd0,   10'h000};

        global_resetn = 1'b0;
        in_valid = 1'b0; is_signed = 1'b0; out_ready = 1'b1; dataa = '0; datab = '0;
        in_valid2 = 1'b0; is_signed2 = 1'b0; out_ready2 = 1'b1; dataa2 = '0; datab2 = '0;
        #12;
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_in_ready",  longint'(in_ready),  1);
        check("reset_busy",      longint'(busy),      0);
        check("reset_dataout",   longint'(dataout),   0);
        @(negedge clock0);
        global_resetn = 1'b1;
        @(negedge clock0);

        for (int i = 0; i < 10; i++) begin
            run1(vecs[i].s, vecs[i].a, vecs[i].b, 0, lat, bcnt, res, rdy);
            check($sformatf("vec%0d_product", i), longint'(res), longint'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), lat, 5);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, 5);
            check($sformatf("vec%0d_ready_after", i), longint'(rdy), 1);
        end

        // Backpressure with operands offered in RUN and DONE that must be ignored
        run1(1'b0, 5'd31, 5'd31, 0, lat, bcnt, res, rdy);
        is_signed = 1'b0; dataa = 5'd5; datab = 5'd6; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clock0);
        in_valid = 1'b1; dataa = 5'd3; datab = 5'd3;
        @(negedge clock0);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clock0);
            guard++;
        end
        check("bp_reached_done", longint'(out_valid), 1);
        bad = 0;
        in_valid = 1'b1; dataa = 5'd1; datab = 5'd1;
        for (int i = 0; i < 8; i++) begin
            if (!out_valid || dataout != 10'd30 || in_ready) bad++;
            @(negedge clock0);
        end
        in_valid = 1'b0;
        check("bp_hold_violations", bad, 0);
        check("bp_dataout", longint'(dataout), 30);
        out_ready = 1'b1;
        @(negedge clock0);
        check("bp_ready_after", longint'(in_ready), 1);
        check("bp_dataout_retained", longint'(dataout), 30);
        run1(1'b0, 5'd2, 5'd3, 0, lat, bcnt, res, rdy);
        check("bp_next_product", longint'(res), 6);

        // Asynchronous reset in the third RUN cycle of 7*9
        run1(1'b0, 5'd31, 5'd31, 0, lat, bcnt, res, rdy);
        is_signed = 1'b0; dataa = 5'd7; datab = 5'd9; in_valid = 1'b1;
        @(negedge clock0);
        in_valid = 1'b0;
        @(negedge clock0);
        @(negedge clock0);
        #2 global_resetn = 1'b0;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_in_ready",  longint'(in_ready),  1);
        check("rst_busy",      longint'(busy),      0);
        check("rst_dataout",   longint'(dataout),   0);
        @(negedge clock0);
        global_resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock0);
            if (out_valid || busy || !in_ready) bad++;
        end
        check("rst_no_stale_product", bad, 0);
        run1(1'b0, 5'd7, 5'd9, 0, lat, bcnt, res, rdy);
        check("rst_after_product", longint'(res), 63);
        check("rst_after_latency", lat, 5);

        // Random regression, 5x5
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            s = 1'($urandom_range(0, 1));
            a = 5'($urandom_range(0, 31));
            b = 5'($urandom_range(0, 31));
            run1(s, a, b, int'($urandom_range(0, 3)), lat, bcnt, res, rdy);
            if (lat != 5 || longint'(res) != model(s, longint'(a), longint'(b), 5, 5, 10)) begin
                bad++;
                $display("FAIL rand5x5 s=%0d a=%0d b=%0d actual=%0d required=%0d lat=%0d",
                         s, a, b, res, model(s, longint'(a), longint'(b), 5, 5, 10), lat);
            end
        end
        check("rand5x5_mismatches", bad, 0);

        // Random regression, 8x6 plus the signed corner
        run2(1'b1, 8'h80, 6'h20, 0, lat, res2);
        check("w86_min_min", longint'(res2), 4096);
        check("w86_latency", lat, 6);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            s  = 1'($urandom_range(0, 1));
            a2 = 8'($urandom_range(0, 255));
            b2 = 6'($urandom_range(0, 63));
            run2(s, a2, b2, int'($urandom_range(0, 3)), lat, res2);
            if (lat != 6 || longint'(res2) != model(s, longint'(a2), longint'(b2), 8, 6, 14)) begin
                bad++;
                $display("FAIL rand8x6 s=%0d a=%0d b=%0d actual=%0d required=%0d lat=%0d",
                         s, a2, b2, res2, model(s, longint'(a2), longint'(b2), 8, 6, 14), lat);
            end
        end
        check("rand8x6_mismatches", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
